dmem_port_arbiter: RTL
======================

# dmem_port_arbiter

Arbiter and readout sequencer for the single-port program (data) memory. It shares the memory port between the CPU load/store path and a dump engine. On request, the dump engine reads a contiguous range of 32-bit words and streams each one out as four bytes, least-significant byte first, over an 8-bit valid/ready channel. The block sits between the CPU core, the program RAM and the top-level output pins, and replaces ad-hoc byte-slicing of the RAM output.

## Interface
Parameters:
- `ADDR_W`, default 5: memory word-address width; depth is 2^ADDR_W.
- `HOLD_MAX`, default 8: maximum number of consecutive CPU grants while a dump read is pending; must be ≥1.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `cpu_req`  in  1: CPU memory access request.
- `cpu_we`  in  1: write (1) or read (0); sampled with `cpu_req`.
- `cpu_addr`  in  ADDR_W: CPU word address.
- `cpu_wdata`  in  32: CPU write data.
- `cpu_gnt`  out  1: combinational; the CPU access is performed this cycle.
- `cpu_rvalid`  out  1: read data valid; asserted one cycle after a granted read.
- `cpu_rdata`  out  32: equals `mem_rdata`; meaningful only when `cpu_rvalid` is high.
- `dump_start`  in  1: single-cycle pulse that requests a dump.
- `dump_base`  in  ADDR_W: first word address of the dump; sampled on `dump_start`.
- `dump_len`  in  ADDR_W+1: number of words to dump; sampled on `dump_start`.
- `dump_busy`  out  1: high from the cycle after an accepted start until the done pulse.
- `dump_done`  out  1: one-cycle pulse marking the end of a dump.
- `dump_byte`  out  8: streamed byte.
- `dump_valid`  out  1: `dump_byte` is valid.
- `dump_ready`  in  1: sink accepts the byte.
- `mem_we`  out  1: memory write enable.
- `mem_addr`  out  ADDR_W: memory address.
- `mem_wdata`  out  32: memory write data.
- `mem_rdata`  in  32: memory read data, with 1-cycle registered read latency.

## Operation
- Port mux, combinational:
  - CPU winner: `mem_addr`=`cpu_addr`, `mem_wdata`=`cpu_wdata`, `mem_we`=`cpu_we`.
  - Dump winner: `mem_addr`=dump pointer, `mem_we`=0.
  - No winner: `mem_we`=0, and `mem_addr`/`mem_wdata` are 0.
- Arbitration:
  - CPU has fixed priority.
  - The dump engine wins only when it is in REQ and either `cpu_req`=0 or `hold_cnt`==HOLD_MAX.
  - `hold_cnt` increments on each CPU grant while the dump is in REQ.
  - `hold_cnt` clears when the dump wins or when the dump leaves REQ.
- Dump FSM states: IDLE, REQ, WAIT, SHIFT, DONE.
  - IDLE: on `dump_start` with `dump_len`≠0, latch the pointer (`dump_base`) and the remaining count (`dump_len`), then go to REQ.
  - IDLE: `dump_start` with `dump_len`=0 → DONE without any memory access.
  - REQ: on a dump grant → WAIT.
  - WAIT: capture `mem_rdata` into a 32-bit shift register, set byte index 0 → SHIFT.
  - SHIFT: `dump_valid`=1 and `dump_byte`=shift[7:0].
    - On `dump_valid && dump_ready`, shift right by 8 and increment the index.
    - After the 4th byte, decrement the count and increment the pointer, wrapping modulo 2^ADDR_W.
    - Then go to REQ if the count is ≠0, else DONE.
  - DONE: pulse `dump_done` for one cycle → IDLE.
- `dump_start` is ignored in every state except IDLE.
- While SHIFT waits on `dump_ready`, `dump_byte` stays stable and the memory port is free for the CPU.
- The CPU has no stall path beyond `cpu_gnt`; it must hold its request until granted.
- The block does not buffer a denied request.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, `hold_cnt`=0, and the shift register is 0.
- Reset mid-dump aborts immediately. No `dump_done` is issued for the aborted dump.
- CPU read: granted in cycle N → `cpu_rvalid`=1 in cycle N+1 with the data.
- Dump first byte: `dump_start` in cycle N with an idle CPU gives:
  - REQ in N+1, grant in N+1;
  - WAIT in N+2;
  - `dump_valid` in N+3.
- Per word, with the sink always ready and the CPU idle: 1 REQ + 1 WAIT + 4 SHIFT cycles = 6 cycles.
- Worst-case dump grant delay under continuous CPU requests: HOLD_MAX+1 cycles from entering REQ.
- `dump_busy` is high in REQ, WAIT and SHIFT. It is low in IDLE and DONE.

## Configuration
- `DUMP_CHECKSUM_EN` defined:
  - After the last word's 4th byte, the FSM passes through a CHECK state.
  - CHECK emits one extra byte: the XOR of every streamed byte in this dump.
  - The byte uses the same valid/ready handshake, then the FSM goes to DONE.
  - For `dump_len`=0, no checksum byte is sent.
- Undefined: the CHECK state and the XOR register are absent, and the last byte goes directly to DONE.

## Test plan
- Reset, then idle: all outputs 0. A CPU write of 0xDEADBEEF to addr 3 gives `cpu_gnt`=1 and `mem_we`=1 in the same cycle. A read of addr 3 gives `cpu_rvalid` and data 0xDEADBEEF one cycle later.
- RAM[0]=0x44332211, dump base 0, len 1, `dump_ready` held 1: bytes 0x11, 0x22, 0x33, 0x44 on consecutive cycles starting 3 cycles after start. `dump_done` pulses once. With `DUMP_CHECKSUM_EN`, 0x44 is followed by a 5th byte 0x44 (XOR of the four bytes).
- Wrap: ADDR_W=5, base 31, len 2: `mem_addr` reads are 31 then 0.
- Starvation: `cpu_req` held high with HOLD_MAX=8 during a dump: `cpu_gnt` is low for exactly one cycle after 8 consecutive CPU grants. The dump word is read and streamed.
- Backpressure: `dump_ready` low for 5 cycles mid-word: `dump_byte` stays constant and the CPU can still access memory. The byte order is preserved once ready rises.
- `dump_start` during busy is ignored. `rst` asserted mid-dump: next cycle all outputs are 0 and the FSM is IDLE, with no `dump_done`.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single data-memory port between the CPU
// load/store path (fixed priority, bounded by HOLD_MAX) and a dump engine
// that reads a word range and streams it out LSB byte first.
// Optional build macro DUMP_CHECKSUM_EN appends an XOR checksum byte.
// Byte channel handshake: a byte moves on every rising edge where
// dump_valid && dump_ready; dump_byte is held stable while dump_valid is
// high and dump_ready is low, and dump_valid never drops without a transfer.
module dmem_port_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int HOLD_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [31:0]       cpu_rdata,
    input  logic              dump_start,
    input  logic [ADDR_W-1:0] dump_base,
    input  logic [ADDR_W:0]   dump_len,
    output logic              dump_busy,
    output logic              dump_done,
    output logic [7:0]        dump_byte,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [2:0]        dump_state
);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int HOLD_W = $clog2(HOLD_MAX + 1);

`ifdef DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_REQ = 3'd1, S_WAIT = 3'd2, S_SHIFT = 3'd3,
        S_DONE = 3'd4, S_CHECK = 3'd5
    } state_t;
    localparam state_t S_AFTER_LAST = S_CHECK;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_REQ = 3'd1, S_WAIT = 3'd2, S_SHIFT = 3'd3,
        S_DONE = 3'd4
    } state_t;
    localparam state_t S_AFTER_LAST = S_DONE;
`endif

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] ptr;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       shift;
    logic [1:0]        idx;
    logic [HOLD_W-1:0] hold_cnt;
    logic              dump_win;
    logic              last_byte;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    // The dump takes the port when the CPU is quiet or has used up its hold budget.
    assign dump_win  = (state == S_REQ) && (!cpu_req || hold_cnt == HOLD_W'(HOLD_MAX));
    assign last_byte = (state == S_SHIFT) && dump_ready && (idx == 2'd3);
    assign cpu_rdata = mem_rdata;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic of the dump sequencer.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (dump_start) state_nx = (dump_len != '0) ? S_REQ : S_DONE;
            S_REQ:   if (dump_win) state_nx = S_WAIT;
            S_WAIT:  state_nx = S_SHIFT;
            S_SHIFT: if (last_byte) state_nx = (cnt == CNT_W'(1)) ? S_AFTER_LAST : S_REQ;
`ifdef DUMP_CHECKSUM_EN
            S_CHECK: if (dump_ready) state_nx = S_DONE;
`endif
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Port mux, grant and status outputs decoded from the current state.
    always_comb begin
        cpu_gnt   = cpu_req && !dump_win;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dump_win) begin
            mem_addr  = ptr;
        end
        dump_busy  = (state == S_REQ) || (state == S_WAIT) || (state == S_SHIFT);
        dump_valid = (state == S_SHIFT);
        dump_byte  = (state == S_SHIFT) ? shift[7:0] : 8'h00;
`ifdef DUMP_CHECKSUM_EN
        if (state == S_CHECK) begin
            dump_busy  = 1'b1;
            dump_valid = 1'b1;
            dump_byte  = csum;
        end
`endif
        dump_done  = (state == S_DONE);
        dump_state = state;
    end

    // CPU read-valid pipeline and the CPU hold counter used for starvation bounding.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rvalid <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            cpu_rvalid <= cpu_gnt && !cpu_we;
            if (state != S_REQ || dump_win) hold_cnt <= '0;
            else if (cpu_gnt)               hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end

    // Dump datapath: pointer, word count, shift register and byte index.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            cnt   <= '0;
            shift <= '0;
            idx   <= '0;
`ifdef DUMP_CHECKSUM_EN
            csum  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (dump_start) begin
                        ptr  <= dump_base;
                        cnt  <= dump_len;
`ifdef DUMP_CHECKSUM_EN
                        csum <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    shift <= mem_rdata;
                    idx   <= 2'd0;
                end
                S_SHIFT: begin
                    if (dump_ready) begin
                        shift <= {8'h00, shift[31:8]};
                        idx   <= idx + 2'd1;
`ifdef DUMP_CHECKSUM_EN
                        csum  <= csum ^ shift[7:0];
`endif
                        if (idx == 2'd3) begin
                            cnt <= cnt - CNT_W'(1);
                            ptr <= ptr + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
